mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative RV32M multiply/divide unit that sits directly downstream of the register file read ports (RD1/RD2) and upstream of its write port (WD/Rd/we). It accepts one M-extension operation and stalls the core via busy. After a fixed latency it presents the result, destination index and a one-cycle write enable for register writeback. It uses one bit per cycle: shift-add for multiply, restoring division for divide.

Parameters:
WIDTH, 32, operand/result width; must be even and at least 4.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset; 0 forces the idle state.
start  input  1  request; accepted only when busy=0.
flush  input  1  synchronous abort; discards any in-flight operation.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rd_in  input  5  destination register index, latched on accept.
op_a  input  WIDTH  rs1 value (RD1), latched on accept.
op_b  input  WIDTH  rs2 value (RD2), latched on accept.
busy  output  1  high in CALC and DONE.
done  output  1  one-cycle pulse; result valid.
result  output  WIDTH  final result, held until the next accept.
rd_out  output  5  latched rd_in, held until the next accept.
we_out  output  1  done AND (rd_out != 0); drives the register-file we.

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, done=0, we_out=0, result=0, rd_out=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on a rising edge with start=1 and flush=0 (the accept edge).
  - Latch funct3 and rd_in.
  - Latch operand magnitudes: signed operands as absolute values, unsigned operands as-is. MULHSU treats op_a as signed and op_b as unsigned.
  - Record the result sign, the div-by-zero flag (op_b=0) and the overflow flag (DIV/REM with op_a=100..0 and op_b=all ones).
- CALC: one iteration per edge, counter 0..WIDTH-1; exactly WIDTH edges.
  - Multiply: 2*WIDTH-bit product accumulator.
  - Divide: WIDTH+1-bit partial remainder and WIDTH-bit quotient.
- CALC -> DONE on the edge where counter=WIDTH-1. That same edge registers the sign-corrected result:
  - MUL: low half of the product.
  - MULH/MULHSU/MULHU: high half of the product.
  - DIV/DIVU: quotient, negated if exactly one operand is negative (DIV).
  - REM/REMU: remainder, carrying the sign of the dividend (REM).
  - Div-by-zero: quotient = all ones; remainder = op_a.
  - Overflow: quotient = op_a; remainder = 0.
  - Special cases still take the full latency (no early exit).
- DONE: done=1 and we_out as defined, for exactly one cycle; unconditional transition to IDLE on the next edge.
- Latency: done is high in the cycle after the (WIDTH+1)-th rising edge following the accept edge (WIDTH=32: 33 edges).
- start while busy=1 is ignored with no side effects, including in the DONE cycle. Back-to-back: earliest new accept is the edge that ends DONE, i.e. the first edge where busy=0 is sampled.
- flush=1 at any edge while in CALC or DONE: next state IDLE, done/we_out forced 0 at that edge, result and rd_out unchanged.
- flush=1 in IDLE also blocks accept.
- Reset asserted mid-operation: immediate return to IDLE, all outputs at reset values, no done.
- result and rd_out change only at the DONE-entry edge or on reset.

Decomposition:
- Shared package: funct3 encodings (MUL...REMU), state encoding (IDLE/CALC/DONE), an is_div helper bit (funct3[2]) and the operand-signedness table.
- One natural sub-module, mdu_sign_fix: a combinational block that negates WIDTH-bit values conditionally. It is used both for operand magnitude at accept and for result correction at DONE entry.
- The iteration datapath and FSM stay in the top level.

Test Plan:
- Reset: hold reset=0, drive start=1 -> busy=0, done=0, we_out=0, result=0 throughout; release reset -> IDLE with no done.
- MUL, op_a=7, op_b=0xFFFFFFFD, rd_in=5 -> done exactly 33 edges after accept; result=0xFFFFFFEB, rd_out=5, we_out=1 for one cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide, op_a=0xFFFFFFF9 (-7), op_b=2:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
- Special cases, with latency still 33 edges:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Handshake:
  - start pulsed mid-CALC is ignored.
  - flush at CALC counter=10 -> IDLE, no done, prior result retained.
  - rd_in=0 -> done=1 with we_out=0.
  - Back-to-back start on the first edge with busy=0 is accepted.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_unit_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - funct3 encodings for the eight M-extension operations
//   - FSM state encoding (IDLE / CALC / DONE)
//   - helpers: divide-class decode and per-operand signedness table
// -----------------------------------------------------------------------------
package mul_div_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Divide-class operations all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Remainder operations (REM/REMU) within the divide class.
  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // op_a is signed for MULH, MULHSU, DIV, REM. MUL is treated as unsigned:
  // the low half of the product does not depend on signedness.
  function automatic logic a_is_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  // op_b is signed for MULH, DIV, REM (MULHSU takes op_b unsigned).
  function automatic logic b_is_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      F3_MULH, F3_DIV, F3_REM: s = 1'b1;
      default:                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// -----------------------------------------------------------------------------
// mdu_sign_fix
// Combinational conditional two's-complement negation.
//   val_in  : value to correct
//   neg     : 1 = output -val_in, 0 = pass through
//   val_out : corrected value
// Used for operand magnitudes at accept and for result sign correction.
// -----------------------------------------------------------------------------
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_in,
  input  logic         neg,
  output logic [W-1:0] val_out
);

  assign val_out = neg ? (~val_in + W'(1)) : val_in;

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative RV32M multiply/divide unit, one bit per cycle (shift-add multiply,
// restoring divide). Sits between register-file read ports and write port.
//   clk, reset      : rising-edge clock, async active-low reset
//   start, flush    : request (accepted when idle) and synchronous abort
//   funct3, rd_in   : operation select and destination index
//   op_a, op_b      : rs1 / rs2 operands
//   busy            : high while CALC or DONE (core stall)
//   done, we_out    : one-cycle result pulse, and register-file write enable
//   result, rd_out  : final result and destination, held until next DONE entry
// -----------------------------------------------------------------------------
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             we_out
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state_q,   state_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic               seed_q,    seed_d;
  logic [2:0]         f3_q,      f3_d;
  logic [4:0]         rd_pend_q, rd_pend_d;
  logic [4:0]         rd_q,      rd_d;
  logic [WIDTH-1:0]   result_q,  result_d;
  logic [WIDTH-1:0]   mag_a_q,   mag_a_d;
  logic [WIDTH-1:0]   mag_b_q,   mag_b_d;
  logic               res_neg_q, res_neg_d;
  logic               div0_q,    div0_d;
  logic               ovf_q,     ovf_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH:0]     rem_q,     rem_d;
  logic [WIDTH-1:0]   quo_q,     quo_d;

  // ---------------------------------------------------------------------------
  // Operand magnitudes for the accept edge
  // ---------------------------------------------------------------------------
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign neg_a = a_is_signed(funct3) & op_a[WIDTH-1];
  assign neg_b = b_is_signed(funct3) & op_b[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH)) u_fix_a (.val_in(op_a), .neg(neg_a), .val_out(abs_a));
  mdu_sign_fix #(.W(WIDTH)) u_fix_b (.val_in(op_b), .neg(neg_b), .val_out(abs_b));

  // ---------------------------------------------------------------------------
  // One iteration of each datapath, computed from the current registers
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic               div_fits;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   quo_step;

  // Shift-add: conditionally add the multiplicand into the upper half, then
  // shift the whole accumulator right; the multiplier drains out of the bottom.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mag_a_q} : '0);
  assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring division: bring in the next dividend bit and subtract the
  // divisor; keep the difference only when it did not borrow.
  assign div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, mag_b_q};
  assign div_fits  = ~div_trial[WIDTH+1];
  assign rem_step  = div_fits ? div_trial[WIDTH:0] : div_shift;
  assign quo_step  = {quo_q[WIDTH-2:0], div_fits};

  // ---------------------------------------------------------------------------
  // Result selection and sign correction for the DONE-entry edge
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   div_raw;
  logic [2*WIDTH-1:0] fix_in, fix_out;
  logic [WIDTH-1:0]   final_res;

  assign div_raw = is_rem(f3_q) ? rem_step[WIDTH-1:0] : quo_step;
  // Divide values are zero-extended so the low half negates correctly mod 2^W.
  assign fix_in  = is_div(f3_q) ? {{WIDTH{1'b0}}, div_raw} : acc_step;

  mdu_sign_fix #(.W(2*WIDTH)) u_fix_res (.val_in(fix_in), .neg(res_neg_q), .val_out(fix_out));

  always_comb begin
    final_res = fix_out[WIDTH-1:0];
    if (is_div(f3_q)) begin
      if (div0_q && !is_rem(f3_q))     final_res = '1;
      else if (ovf_q && is_rem(f3_q))  final_res = '0;
      else if (ovf_q)                  final_res = {1'b1, {(WIDTH-1){1'b0}}};
    end else if (f3_q != F3_MUL) begin
      final_res = fix_out[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath next-state
  // ---------------------------------------------------------------------------
  // NOTE: every _d gets its hold value first so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seed_d    = seed_q;
    f3_d      = f3_q;
    rd_pend_d = rd_pend_q;
    rd_d      = rd_q;
    result_d  = result_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    res_neg_d = res_neg_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    quo_d     = quo_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d   = ST_CALC;
          cnt_d     = '0;
          seed_d    = 1'b1;
          f3_d      = funct3;
          rd_pend_d = rd_in;
          mag_a_d   = abs_a;
          mag_b_d   = abs_b;
          res_neg_d = is_rem(funct3) ? neg_a : (neg_a ^ neg_b);
          div0_d    = (op_b == '0);
          ovf_d     = is_div(funct3) && !funct3[0]
                    && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
        end
      end

      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (seed_q) begin
          // First CALC edge loads the iteration registers from the magnitudes.
          seed_d = 1'b0;
          acc_d  = {{WIDTH{1'b0}}, mag_b_q};
          rem_d  = '0;
          quo_d  = mag_a_q;
        end else begin
          acc_d = acc_step;
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d  = ST_DONE;
            cnt_d    = '0;
            result_d = final_res;
            rd_d     = rd_pend_q;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  // Datapath registers are reset as well, giving defined values after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      seed_q    <= 1'b0;
      f3_q      <= '0;
      rd_pend_q <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      res_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      f3_q      <= f3_d;
      rd_pend_q <= rd_pend_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      res_neg_q <= res_neg_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign rd_out = rd_q;
  assign we_out = done && (rd_q != 5'd0);

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .funct3(funct3), .rd_in(rd_in), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we_out(we_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'd0: begin p = ua * ub;           return p[31:0];  end
      3'd1: begin p = sa * sb;           return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive a request at the falling edge and return after the accept edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
  endtask

  // Count rising edges until done is seen (sampled 1 time unit after edge).
  task automatic wait_done(input bit mid_pulse, output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (mid_pulse && n == 15) begin
        start = 1'b1; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'd31;
      end
      if (mid_pulse && n == 16) start = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input bit mid_pulse);
    int n;
    logic [31:0] exp;
    exp = model(f3, a, b);
    issue(f3, a, b, rd);
    check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    wait_done(mid_pulse, n);
    check({tag, " latency"}, n, 33);
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    check({tag, " we_out"}, 32'(we_out), 32'(rd != 5'd0));
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, {30'd0, done, we_out}, 32'd0);
    check({tag, " idle_after_done"}, 32'(busy), 32'd0);
    check({tag, " result_held"}, result, exp);
  endtask

  initial begin
    int          n;
    bit          seen;
    logic [31:0] prev_res, a, b;
    logic [4:0]  prev_rd, rd;
    logic [2:0]  f3;

    // Reset held with start asserted: nothing may happen.
    start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", i), {busy, done, we_out, rd_out, result[23:0]}, 32'd0);
    end
    check("reset_result", result, 32'd0);
    @(negedge clk); start = 1'b0; reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; seen |= done | busy; end
    check("reset_release_idle", 32'(seen), 32'd0);

    // Directed operations.
    run_op("mul_neg",       3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  1'b0);
    run_op("mulh_min",      3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  1'b0);
    run_op("mulhu_max",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  1'b0);
    run_op("mulhsu_max",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  1'b0);
    run_op("div_neg",       3'd4, 32'hFFFF_FFF9, 32'd2,         5'd10, 1'b0);
    run_op("rem_neg",       3'd6, 32'hFFFF_FFF9, 32'd2,         5'd11, 1'b0);
    run_op("divu_zero",     3'd5, 32'd5,         32'd0,         5'd12, 1'b0);
    run_op("remu_zero",     3'd7, 32'd5,         32'd0,         5'd13, 1'b0);
    run_op("div_zero_neg",  3'd4, 32'hFFFF_FFF9, 32'd0,         5'd14, 1'b0);
    run_op("div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0);
    run_op("rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0);
    run_op("start_midcalc", 3'd5, 32'd1000,      32'd7,         5'd17, 1'b1);
    run_op("rd_zero",       3'd0, 32'd12,        32'd12,        5'd0,  1'b0);

    // Flush at counter 10: edges after accept are seed, then counter 0,1,...
    prev_res = result; prev_rd = rd_out;
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20);
    for (int i = 0; i < 11; i++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {30'd0, busy, done}, 32'd0);
    check("flush_result_kept", result, prev_res);
    check("flush_rd_kept", 32'(rd_out), 32'(prev_rd));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; seen |= done; end
    check("flush_no_done", 32'(seen), 32'd0);

    // Back-to-back: start held through the DONE cycle is ignored there and
    // accepted on the first edge that samples busy=0.
    issue(3'd4, 32'd100, 32'd9, 5'd21);
    wait_done(1'b0, n);
    check("b2b_first_latency", n, 33);
    check("b2b_first_result", result, model(3'd4, 32'd100, 32'd9));
    start = 1'b1; funct3 = 3'd7; op_a = 32'd100; op_b = 32'd9; rd_in = 5'd22;
    @(posedge clk); #1;
    check("b2b_ignored_in_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accepted", 32'(busy), 32'd1);
    wait_done(1'b0, n);
    check("b2b_second_latency", n, 33);
    check("b2b_second_result", result, 32'd1);
    check("b2b_second_rd", 32'(rd_out), 32'd22);
    @(posedge clk); #1;

    // Reset asserted mid-operation.
    issue(3'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd23);
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("midreset_outputs", {busy, done, we_out, rd_out, 24'd0}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(negedge clk); reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; seen |= done | busy; end
    check("midreset_no_done", 32'(seen), 32'd0);

    // Randomized operations, with divide-by-zero and overflow mixed in.
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(7, 0));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      case ($urandom_range(7, 0))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(15, 1));
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, rd, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
